// File: rtl/nway_dcache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and a self-sequenced flush that ends by writing the hit count.
//
// state | meaning
// IDLE  | serve hits, detect misses, sample halt
// WB    | write the dirty victim block back, one word per accepted transfer
// FILL  | read the requested block into the victim way
// FLUSH | walk every set/way, writing back dirty blocks
// CNT   | write hit_count to HITCNT_ADDR
// DONE  | flush complete, cache inert until reset
module nway_dcache #(
   parameter int          WAYS        = 4,
   parameter int          SETS        = 8,
   parameter int          BLKWORDS    = 2,
   parameter logic [31:0] HITCNT_ADDR = 32'h00003100
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   input  logic        dwait,
   input  logic [31:0] dload,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore
);
   localparam int OW = $clog2(BLKWORDS);
   localparam int KW = (OW > 0) ? OW : 1;
   localparam int IW = $clog2(SETS);
   localparam int AW = $clog2(WAYS);
   localparam int TW = 30 - OW - IW;
   localparam int FW = IW + AW;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WB    = 3'd1;
   localparam logic [2:0] S_FILL  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_CNT   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [31:0]     data  [WAYS][SETS][BLKWORDS];
   logic [TW-1:0]   tags  [WAYS][SETS];
   logic [WAYS-1:0] valid [SETS];
   logic [WAYS-1:0] dirty [SETS];
   logic [AW-1:0]   age   [SETS][WAYS];

   logic [2:0]    state;
   logic [KW-1:0] k;
   logic [AW-1:0] vic_way;
   logic [FW-1:0] fcnt;
   logic [31:0]   hit_count;

   logic [KW-1:0] blkoff;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic          req, hit_any, last_k, f_dirty;
   logic [AW-1:0] hit_way, vic_sel, f_way;
   logic [IW-1:0] f_set;

   function automatic logic [31:0] blk_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                            input logic [KW-1:0] kk);
      blk_addr = (32'(t) << (2 + OW + IW)) | (32'(i) << (2 + OW)) | (32'(kk) << 2);
   endfunction

   assign blkoff  = KW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));
   assign idx     = IW'(dmemaddr >> (2 + OW));
   assign tag     = TW'(dmemaddr >> (2 + OW + IW));
   assign req     = dmemREN | dmemWEN;
   assign last_k  = (k == KW'(BLKWORDS - 1));
   assign f_way   = fcnt[AW-1:0];
   assign f_set   = fcnt[FW-1:AW];
   assign f_dirty = valid[f_set][f_way] & dirty[f_set][f_way];

   // Victim: lowest invalid way wins, else the oldest (age WAYS-1).
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      vic_sel = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[idx][w] && tags[w][idx] == tag) begin
            hit_any = 1'b1;
            hit_way = AW'(w);
         end
         if (age[idx][w] == AW'(WAYS - 1)) vic_sel = AW'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[idx][w]) vic_sel = AW'(w);
   end

   assign dhit     = (state == S_IDLE) && !halt && req && hit_any;
   assign dmemload = dhit ? data[hit_way][idx][blkoff] : 32'd0;
   assign flushed  = (state == S_DONE);

   always_comb begin
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = '0;
      dstore = '0;
      case (state)
         S_WB: begin
            dWEN   = 1'b1;
            daddr  = blk_addr(tags[vic_way][idx], idx, k);
            dstore = data[vic_way][idx][k];
         end
         S_FILL: begin
            dREN  = 1'b1;
            daddr = blk_addr(tag, idx, k);
         end
         S_FLUSH: if (f_dirty) begin
            dWEN   = 1'b1;
            daddr  = blk_addr(tags[f_way][f_set], f_set, k);
            dstore = data[f_way][f_set][k];
         end
         S_CNT: begin
            dWEN   = 1'b1;
            daddr  = HITCNT_ADDR;
            dstore = hit_count;
         end
         default: ;
      endcase
   end

   // Line payload and tags carry no reset; valid bits gate every use.
   always_ff @(posedge CLK) begin
      if (dhit && dmemWEN) data[hit_way][idx][blkoff] <= dmemstore;
      if (state == S_FILL && !dwait) begin
         data[vic_way][idx][k] <= dload;
         if (last_k) tags[vic_way][idx] <= tag;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= S_IDLE;
         k         <= '0;
         vic_way   <= '0;
         fcnt      <= '0;
         hit_count <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (halt) begin
                  state <= S_FLUSH;
                  fcnt  <= '0;
                  k     <= '0;
               end else if (req) begin
                  if (hit_any) begin
                     hit_count <= hit_count + 32'd1;
                     for (int w = 0; w < WAYS; w++)
                        if (age[idx][w] < age[idx][hit_way]) age[idx][w] <= age[idx][w] + 1'b1;
                     age[idx][hit_way] <= '0;
                     if (dmemWEN) dirty[idx][hit_way] <= 1'b1;
                  end else begin
                     vic_way <= vic_sel;
                     k       <= '0;
                     state   <= (valid[idx][vic_sel] && dirty[idx][vic_sel]) ? S_WB : S_FILL;
                  end
               end
            end
            S_WB: if (!dwait) begin
               k <= last_k ? '0 : k + 1'b1;
               if (last_k) begin
                  dirty[idx][vic_way] <= 1'b0;
                  state               <= S_FILL;
               end
            end
            S_FILL: if (!dwait) begin
               k <= last_k ? '0 : k + 1'b1;
               if (last_k) begin
                  valid[idx][vic_way] <= 1'b1;
                  dirty[idx][vic_way] <= 1'b0;
                  state               <= S_IDLE;
               end
            end
            S_FLUSH: begin
               if (!f_dirty || (!dwait && last_k)) begin
                  if (f_dirty) dirty[f_set][f_way] <= 1'b0;
                  fcnt <= fcnt + 1'b1;
                  if (fcnt == '1) state <= S_CNT;
               end
               if (f_dirty && !dwait) k <= last_k ? '0 : k + 1'b1;
            end
            S_CNT: if (!dwait) state <= S_DONE;
            default: state <= S_DONE;
         endcase
      end
   end
endmodule

// File: tb/tb_nway_dcache.sv
// Directed bench for nway_dcache: a fixed-latency memory responder logs every
// completed transfer, and each scenario task checks hits, data and traffic.
module tb_nway_dcache;
   logic        CLK, nRST;
   logic        dmemREN, dmemWEN, halt, dwait;
   logic [31:0] dmemaddr, dmemstore, dload;
   logic        dhit, flushed, dREN, dWEN;
   logic [31:0] dmemload, daddr, dstore;

   nway_dcache dut (
      .CLK(CLK), .nRST(nRST),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
      .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       log_q[$];
   logic [31:0] mem [logic [31:0]];
   int          busy;
   int          vectors = 0;
   int          miscompares = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A0000;
   endfunction

   // Memory: every word is held off for two cycles, then accepted.
   always @(negedge CLK) begin
      if (dREN || dWEN) begin
         dload = mem_rd(daddr);
         if (busy == 2) begin
            dwait = 1'b0;
            busy  = 0;
            log_q.push_back('{dWEN, daddr, dWEN ? dstore : mem_rd(daddr)});
            if (dWEN) mem[daddr] = dstore;
         end else begin
            dwait = 1'b1;
            busy++;
         end
      end else begin
         dwait = 1'b1;
         busy  = 0;
      end
   end

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int cyc);
      @(negedge CLK);
      dmemaddr  = a;
      dmemstore = wd;
      dmemREN   = !we;
      dmemWEN   = we;
      cyc = 0;
      #1;
      while (!dhit && cyc < 300) begin
         @(negedge CLK);
         #1;
         cyc++;
      end
      if (!dhit) begin
         vectors++; miscompares++;
         $display("FAIL access_timeout addr=%h: no dhit within %0d cycles", a, cyc);
      end
      rd = dmemload;
      @(posedge CLK);
      #1;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      dmemREN = 1'b1; dmemaddr = 32'h40;
      #12;
      vectors++;
      if ({dhit, flushed, dREN, dWEN, dmemload, daddr, dstore} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got dhit=%b fl=%b ren=%b wen=%b load=%h addr=%h store=%h want all 0",
                  dhit, flushed, dREN, dWEN, dmemload, daddr, dstore);
      end
      @(negedge CLK);
      dmemREN = 1'b0;
      nRST = 1'b1;
   endtask

   task automatic test_cold_read;
      logic [31:0] rd; int cyc; int base;
      base = log_q.size();
      access(1'b0, 32'h44, 32'h0, rd, cyc);
      vectors++;
      if (rd !== 32'h22222222) begin miscompares++; $display("FAIL cold_read_data got %h want 22222222", rd); end
      vectors++;
      if (log_q.size() != base + 2 || log_q[base].we !== 1'b0 || log_q[base].addr !== 32'h40 ||
          log_q[base+1].we !== 1'b0 || log_q[base+1].addr !== 32'h44) begin
         miscompares++;
         $display("FAIL cold_read_traffic got %0d transfers want reads of 40 then 44", log_q.size() - base);
      end
      access(1'b0, 32'h40, 32'h0, rd, cyc);
      vectors++;
      if (rd !== 32'h11111111 || cyc != 0) begin
         miscompares++; $display("FAIL reread_40 got %h cyc=%0d want 11111111 cyc=0", rd, cyc);
      end
   endtask

   task automatic test_write_hit;
      logic [31:0] rd; int cyc; int base;
      base = log_q.size();
      access(1'b1, 32'h44, 32'hDEADBEEF, rd, cyc);
      vectors++;
      if (cyc != 0 || log_q.size() != base) begin
         miscompares++; $display("FAIL write_hit got cyc=%0d xfers=%0d want 0 0", cyc, log_q.size() - base);
      end
      access(1'b0, 32'h44, 32'h0, rd, cyc);
      vectors++;
      if (rd !== 32'hDEADBEEF || cyc != 0) begin
         miscompares++; $display("FAIL write_readback got %h cyc=%0d want deadbeef cyc=0", rd, cyc);
      end
   endtask

   task automatic test_lru;
      logic [31:0] rd; int cyc; int base;
      logic [31:0] seq [6] = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h40, 32'h140};
      logic [31:0] keep [3] = '{32'h40, 32'hC0, 32'h100};
      for (int i = 0; i < 6; i++) access(1'b0, seq[i], 32'h0, rd, cyc);
      vectors++;
      if (rd !== 32'h5A5A0140) begin miscompares++; $display("FAIL lru_fill_140 got %h want 5a5a0140", rd); end
      for (int i = 0; i < 3; i++) begin
         base = log_q.size();
         access(1'b0, keep[i], 32'h0, rd, cyc);
         vectors++;
         if (cyc != 0 || log_q.size() != base) begin
            miscompares++; $display("FAIL lru_keep addr=%h got cyc=%0d want hit", keep[i], cyc);
         end
      end
      base = log_q.size();
      access(1'b0, 32'h80, 32'h0, rd, cyc);
      vectors++;
      if (log_q.size() != base + 2 || rd !== 32'h5A5A0080) begin
         miscompares++;
         $display("FAIL lru_victim_80 got xfers=%0d data=%h want 2 5a5a0080", log_q.size() - base, rd);
      end
   endtask

   task automatic test_dirty_evict;
      logic [31:0] rd; int cyc; int base;
      logic        ewe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] ead [4] = '{32'h80, 32'h84, 32'h140, 32'h144};
      logic [31:0] edt [4] = '{32'hCAFEF00D, 32'h5A5A0084, 32'h5A5A0140, 32'h5A5A0144};
      access(1'b1, 32'h80, 32'hCAFEF00D, rd, cyc);
      access(1'b0, 32'h40, 32'h0, rd, cyc);
      access(1'b0, 32'hC0, 32'h0, rd, cyc);
      access(1'b0, 32'h100, 32'h0, rd, cyc);
      base = log_q.size();
      access(1'b0, 32'h140, 32'h0, rd, cyc);
      vectors++;
      if (log_q.size() != base + 4) begin
         miscompares++; $display("FAIL evict_count got %0d transfers want 4", log_q.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (log_q[base+i].we !== ewe[i] || log_q[base+i].addr !== ead[i] || log_q[base+i].data !== edt[i]) begin
               miscompares++;
               $display("FAIL evict_xfer%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h", i,
                        log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data, ewe[i], ead[i], edt[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_fill;
      logic [31:0] rd; int cyc; int base; int n;
      @(negedge CLK);
      dmemaddr = 32'h200; dmemREN = 1'b1;
      base = log_q.size();
      n = 0;
      while (log_q.size() < base + 1 && n < 100) begin @(posedge CLK); n++; end
      vectors++;
      if (log_q.size() < base + 1) begin miscompares++; $display("FAIL mid_fill_timeout got no first word"); end
      #2;
      nRST = 1'b0;
      #1;
      vectors++;
      if ({dhit, flushed, dREN, dWEN, dmemload, daddr, dstore} !== '0) begin
         miscompares++;
         $display("FAIL mid_fill_reset got ren=%b addr=%h dhit=%b want all 0", dREN, daddr, dhit);
      end
      @(negedge CLK);
      dmemREN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      base = log_q.size();
      access(1'b0, 32'h200, 32'h0, rd, cyc);
      vectors++;
      if (log_q.size() != base + 2 || log_q[base].addr !== 32'h200 || log_q[base+1].addr !== 32'h204 ||
          rd !== 32'h5A5A0200) begin
         miscompares++;
         $display("FAIL refill_after_reset got xfers=%0d data=%h want 2 5a5a0200", log_q.size() - base, rd);
      end
   endtask

   task automatic test_flush;
      logic [31:0] rd; int cyc; int base; int n;
      logic        awe [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] aad [7] = '{32'h40, 32'h40, 32'h84, 32'h44, 32'h80, 32'h40, 32'h84};
      logic [31:0] awd [7] = '{32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [31:0] ard [7] = '{32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'hCAFEF00D, 32'hAAAA0001, 32'hBBBB0002};
      logic [31:0] fad [5] = '{32'h40, 32'h44, 32'h80, 32'h84, 32'h3100};
      logic [31:0] fdt [5] = '{32'hAAAA0001, 32'h22222222, 32'hCAFEF00D, 32'hBBBB0002, 32'd7};
      @(negedge CLK); nRST = 1'b0;
      @(negedge CLK); nRST = 1'b1;
      for (int i = 0; i < 7; i++) begin
         access(awe[i], aad[i], awd[i], rd, cyc);
         if (!awe[i]) begin
            vectors++;
            if (rd !== ard[i]) begin
               miscompares++; $display("FAIL flush_prep%0d addr=%h got %h want %h", i, aad[i], rd, ard[i]);
            end
         end
      end
      base = log_q.size();
      @(negedge CLK); halt = 1'b1;
      @(posedge CLK); #1 halt = 1'b0;
      n = 0;
      while (!flushed && n < 1000) begin @(negedge CLK); n++; end
      vectors++;
      if (log_q.size() != base + 5) begin
         miscompares++; $display("FAIL flush_count got %0d transfers want 5 (flushed=%b)", log_q.size() - base, flushed);
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (log_q[base+i].we !== 1'b1 || log_q[base+i].addr !== fad[i] || log_q[base+i].data !== fdt[i]) begin
               miscompares++;
               $display("FAIL flush_xfer%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                        log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data, fad[i], fdt[i]);
            end
         end
      end
      dmemaddr = 32'h40; dmemREN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); #1;
         vectors++;
         if (flushed !== 1'b1 || dhit !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) begin
            miscompares++;
            $display("FAIL done_sticky got fl=%b dhit=%b ren=%b wen=%b want 1 0 0 0", flushed, dhit, dREN, dWEN);
         end
      end
      dmemREN = 1'b0;
   endtask

   initial begin
      dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dwait = 1'b1;
      dmemaddr = '0; dmemstore = '0; dload = '0; busy = 0;
      mem[32'h40] = 32'h11111111;
      mem[32'h44] = 32'h22222222;
      test_reset;
      test_cold_read;
      test_write_hit;
      test_lru;
      test_dirty_evict;
      test_reset_mid_fill;
      test_flush;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
